// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a multiplexed 8-digit, active-low
// seven-segment display bus. Recovers the hex value shown on each digit,
// flags stable undecodable patterns and pulses once per complete scan frame.
// Optional feature macro: SEGDEC_BLANK_EN (all-segments-off is a legal blank,
// reported on the extra output blank[7:0]).
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  an,
   input  logic [6:0]  seg,
   output logic [31:0] digits,
   output logic [7:0]  digit_valid,
   output logic [7:0]  seg_err,
`ifdef SEGDEC_BLANK_EN
   output logic [7:0]  blank,
`endif
   output logic        frame_done
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Returns {decodable, value} for an active-low gfedcba pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h40:   res = 5'h10;
         7'h79:   res = 5'h11;
         7'h24:   res = 5'h12;
         7'h30:   res = 5'h13;
         7'h19:   res = 5'h14;
         7'h12:   res = 5'h15;
         7'h02:   res = 5'h16;
         7'h78:   res = 5'h17;
         7'h00:   res = 5'h18;
         7'h10:   res = 5'h19;
         7'h08:   res = 5'h1A;
         7'h03:   res = 5'h1B;
         7'h46:   res = 5'h1C;
         7'h21:   res = 5'h1D;
         7'h06:   res = 5'h1E;
         7'h0E:   res = 5'h1F;
         default: res = 5'h00;
      endcase
      return res;
   endfunction

   // True when exactly one anode line is driven low.
   function automatic logic is_onehot_low(input logic [7:0] a);
      logic [3:0] lows;
      lows = 4'd0;
      for (int i = 0; i < 8; i++) begin
         lows = lows + {3'd0, ~a[i]};
      end
      return (lows == 4'd1);
   endfunction

   // Index of the lowest low anode bit (only meaningful when one-hot-low).
   function automatic logic [2:0] low_index(input logic [7:0] a);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!a[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [7:0]       an_meta_r, an_sync_r;
   logic [6:0]       seg_meta_r, seg_sync_r;
   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [14:0]      ref_r;
   logic [7:0]       mask_r;

   logic [14:0]      sample_s;
   logic             sample_onehot_s;
   logic             sample_match_s;
   logic             capture_s;
   logic [2:0]       cap_idx_s;
   logic [4:0]       cap_dec_s;
   logic [7:0]       cap_mask_s;
   logic             cap_blank_s;

   assign sample_s        = {an_sync_r, seg_sync_r};
   assign sample_onehot_s = is_onehot_low(an_sync_r);
   assign sample_match_s  = (sample_s == ref_r);
   // Capture fires on the edge where the stability count reaches its target.
   assign capture_s       = (state_r == TRACK) && sample_match_s &&
                            (cnt_r == CNT_W'(STABLE_CYCLES - 1));
   assign cap_idx_s       = low_index(ref_r[14:7]);
   assign cap_dec_s       = seg_decode(ref_r[6:0]);
   assign cap_mask_s      = mask_r | (8'd1 << cap_idx_s);
`ifdef SEGDEC_BLANK_EN
   assign cap_blank_s     = (ref_r[6:0] == 7'h7F);
`else
   assign cap_blank_s     = 1'b0;
`endif

   // Two-flop synchronizer for the asynchronous display bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         an_meta_r  <= 8'hFF;
         an_sync_r  <= 8'hFF;
         seg_meta_r <= 7'h7F;
         seg_sync_r <= 7'h7F;
      end else begin
         an_meta_r  <= an;
         an_sync_r  <= an_meta_r;
         seg_meta_r <= seg;
         seg_sync_r <= seg_meta_r;
      end
   end

   // Acquisition FSM with stability counter, capture and frame tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         ref_r       <= 15'h7FFF;
         mask_r      <= 8'h00;
         digits      <= 32'h0000_0000;
         digit_valid <= 8'h00;
         seg_err     <= 8'h00;
         frame_done  <= 1'b0;
`ifdef SEGDEC_BLANK_EN
         blank       <= 8'h00;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (sample_onehot_s) begin
                  state_r <= TRACK;
                  cnt_r   <= CNT_W'(1);
                  ref_r   <= sample_s;
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
               end
            end
            TRACK, HOLD: begin
               if (sample_match_s) begin
                  if (capture_s) begin
                     state_r <= HOLD;
                     cnt_r   <= CNT_W'(STABLE_CYCLES);
                  end else if (state_r == TRACK) begin
                     cnt_r   <= cnt_r + CNT_W'(1);
                  end else begin
                     state_r <= HOLD;
                  end
               end else if (sample_onehot_s) begin
                  state_r <= TRACK;
                  cnt_r   <= CNT_W'(1);
                  ref_r   <= sample_s;
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase

         if (capture_s) begin
            if (cap_dec_s[4]) begin
               digits[{cap_idx_s, 2'b00} +: 4] <= cap_dec_s[3:0];
               digit_valid[cap_idx_s]          <= 1'b1;
`ifdef SEGDEC_BLANK_EN
               blank[cap_idx_s]                <= 1'b0;
`endif
            end else if (cap_blank_s) begin
`ifdef SEGDEC_BLANK_EN
               blank[cap_idx_s]                <= 1'b1;
`endif
            end else begin
               seg_err[cap_idx_s]              <= 1'b1;
            end
            if (cap_mask_s == 8'hFF) begin
               frame_done <= 1'b1;
               mask_r     <= 8'h00;
            end else begin
               mask_r     <= cap_mask_s;
            end
         end else begin
            mask_r <= mask_r;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder with STABLE_CYCLES=4: directed display-bus
// scenarios, a run-length behavioural model compared every cycle, and
// hand-computed literal expectations.
module tb_seg_scan_decoder;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  an = 8'hFF;
   logic [6:0]  seg = 7'h7F;
   logic [31:0] digits;
   logic [7:0]  digit_valid, seg_err;
   logic        frame_done;
`ifdef SEGDEC_BLANK_EN
   logic [7:0]  blank;
`endif

   seg_scan_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .an(an), .seg(seg),
      .digits(digits), .digit_valid(digit_valid), .seg_err(seg_err),
`ifdef SEGDEC_BLANK_EN
      .blank(blank),
`endif
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int fd_pulses = 0;
   bit started = 1'b0;

   logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model state: delayed bus, run length of identical one-hot samples, outputs.
   logic [7:0]  m_an1 = 8'hFF, m_an2 = 8'hFF;
   logic [6:0]  m_seg1 = 7'h7F, m_seg2 = 7'h7F;
   logic [14:0] m_prev = 15'h7FFF;
   int          run = 0;
   logic [31:0] e_digits = 32'h0;
   logic [7:0]  e_valid = 8'h0, e_err = 8'h0, e_blank = 8'h0, e_mask = 8'h0;
   logic        e_fd = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a digit is accepted when the delayed bus has shown the
   // same one-hot-low pattern for exactly SC consecutive cycles.
   always @(posedge clk) begin
      logic [14:0] samp;
      int          ones;
      int          idx;
      int          val;
      if (reset) begin
         m_an1 = 8'hFF; m_an2 = 8'hFF; m_seg1 = 7'h7F; m_seg2 = 7'h7F;
         m_prev = 15'h7FFF; run = 0;
         e_digits = 32'h0; e_valid = 8'h0; e_err = 8'h0; e_blank = 8'h0;
         e_mask = 8'h0; e_fd = 1'b0;
      end else begin
         samp = {m_an2, m_seg2};
         ones = 0; idx = 0;
         for (int i = 0; i < 8; i++) if (!m_an2[i]) begin ones++; idx = i; end
         if (ones == 1) run = (run > 0 && samp == m_prev) ? run + 1 : 1;
         else run = 0;
         m_prev = samp;
         e_fd = 1'b0;
         if (run == SC) begin
            val = -1;
            for (int v = 0; v < 16; v++) if (pat[v] == m_seg2) val = v;
            if (val >= 0) begin
               e_digits[idx*4 +: 4] = 4'(val);
               e_valid[idx] = 1'b1;
               e_blank[idx] = 1'b0;
            end
`ifdef SEGDEC_BLANK_EN
            else if (m_seg2 == 7'h7F) e_blank[idx] = 1'b1;
`endif
            else e_err[idx] = 1'b1;
            e_mask[idx] = 1'b1;
            if (e_mask == 8'hFF) begin e_fd = 1'b1; e_mask = 8'h0; end
         end
         m_an2 = m_an1; m_an1 = an; m_seg2 = m_seg1; m_seg1 = seg;
      end
   end

   // Compare process: DUT against model on every cycle once running.
   always @(negedge clk) begin
      if (started) begin
         chk("digits", digits, e_digits);
         chk("digit_valid", {24'h0, digit_valid}, {24'h0, e_valid});
         chk("seg_err", {24'h0, seg_err}, {24'h0, e_err});
         chk("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
`ifdef SEGDEC_BLANK_EN
         chk("blank", {24'h0, blank}, {24'h0, e_blank});
`endif
         if (frame_done === 1'b1) fd_pulses++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset held 3 cycles.
      cyc(1);
      started = 1'b1;
      cyc(2);
      chk("rst_digits", digits, 32'h0);
      chk("rst_valid", {24'h0, digit_valid}, 32'h0);
      chk("rst_err", {24'h0, seg_err}, 32'h0);
      chk("rst_fd", {31'h0, frame_done}, 32'h0);
      reset = 1'b0;
      cyc(6);
      chk("idle_fd_pulses", fd_pulses, 0);

      // Single digit, latency check.
      an = 8'hFE; seg = 7'h10;
      cyc(5);
      chk("lat_before", {24'h0, digit_valid}, 32'h0);
      cyc(1);
      chk("lat_valid", {24'h0, digit_valid}, 32'h01);
      chk("lat_digit0", {28'h0, digits[3:0]}, 32'h9);
      cyc(4);

      // Full scan of 1..8.
      for (int d = 0; d < 8; d++) begin
         an = ~(8'd1 << d); seg = pat[d + 1];
         cyc(8);
      end
      chk("scan_digits", digits, 32'h8765_4321);
      chk("scan_valid", {24'h0, digit_valid}, 32'hFF);
      chk("scan_fd_pulses", fd_pulses, 1);

      // Toggling segments never stabilise, then a stable all-off pattern.
      an = 8'hFB;
      for (int k = 0; k < 4; k++) begin
         seg = 7'h40; cyc(2);
         seg = 7'h79; cyc(2);
      end
      chk("toggle_digit2", {28'h0, digits[11:8]}, 32'h3);
      chk("toggle_err", {24'h0, seg_err}, 32'h0);
      seg = 7'h7F;
      cyc(8);
`ifdef SEGDEC_BLANK_EN
      chk("blank_set", {24'h0, blank}, 32'h04);
      chk("blank_err", {24'h0, seg_err}, 32'h00);
`else
      chk("err_set", {24'h0, seg_err}, 32'h04);
`endif

      // Two anodes low: nothing is accepted.
      an = 8'hFC; seg = 7'h40;
      cyc(20);
      chk("multi_digits", digits, 32'h8765_4321);
      chk("multi_valid", {24'h0, digit_valid}, 32'hFF);

      // Reset during TRACK at count 3.
      an = 8'hFF; cyc(3);
      an = 8'hFD; seg = 7'h40;
      cyc(5);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_digits", digits, 32'h0);
      chk("mid_rst_valid", {24'h0, digit_valid}, 32'h0);
      chk("mid_rst_err", {24'h0, seg_err}, 32'h0);
      cyc(1);
      reset = 1'b0;
      cyc(8);
      chk("reacq_valid", {24'h0, digit_valid}, 32'h02);
      chk("reacq_digits", digits, 32'h0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time bound.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
